// File: rtl/frac_lut6_ccff_loader.sv
// Serial programmer for one fracturable-LUT6 configuration chain.
// Takes a parallel configuration word over valid/ready and shifts it into the
// CCFF chain MSB-first. While shifting, it captures the previous chain
// contents from ccff_tail so they can be read back.
//
// Handshake: a word transfers on the rising prog_clock edge where
// cfg_valid && cfg_ready. cfg_ready is high only in IDLE. cfg_valid may be
// held across a busy period without side effects, and cfg_data is only
// sampled on the transfer edge.
module frac_lut6_ccff_loader #(
    parameter int CHAIN_LEN     = 66,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic                 prog_clock,
    input  logic                 prog_reset_n,
    input  logic                 cfg_valid,
    output logic                 cfg_ready,
    input  logic [CHAIN_LEN-1:0] cfg_data,
    input  logic                 cfg_abort,
    output logic                 config_enable,
    output logic                 ccff_head,
    input  logic                 ccff_tail,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    output logic [CHAIN_LEN-1:0] rb_data,
    output logic [1:0]           dbg_state
);

    localparam int CW = $clog2(CHAIN_LEN + 1);
    localparam int SW = $clog2(SETTLE_CYCLES + 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SHIFT  = 2'd1,
        S_SETTLE = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t               state, state_nxt;
    logic [CW-1:0]        cnt, cnt_nxt;
    logic [SW-1:0]        scnt, scnt_nxt;
    // The MSB goes straight to ccff_head on the handshake edge, so only the
    // remaining bits need to be kept for shifting.
    logic [CHAIN_LEN-2:0] shreg, shreg_nxt;
    logic [CHAIN_LEN-1:0] rb_shadow, rb_shadow_nxt;
    logic [CHAIN_LEN-1:0] rb_data_nxt;
    logic                 en_nxt, head_nxt, busy_nxt, done_nxt, err_nxt;

    assign cfg_ready = (state == S_IDLE);
    assign dbg_state = state;

    // State and registered outputs.
    always_ff @(posedge prog_clock or negedge prog_reset_n) begin
        if (!prog_reset_n) begin
            state         <= S_IDLE;
            cnt           <= '0;
            scnt          <= '0;
            shreg         <= '0;
            rb_shadow     <= '0;
            rb_data       <= '0;
            config_enable <= 1'b0;
            ccff_head     <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            err           <= 1'b0;
        end else begin
            state         <= state_nxt;
            cnt           <= cnt_nxt;
            scnt          <= scnt_nxt;
            shreg         <= shreg_nxt;
            rb_shadow     <= rb_shadow_nxt;
            rb_data       <= rb_data_nxt;
            config_enable <= en_nxt;
            ccff_head     <= head_nxt;
            busy          <= busy_nxt;
            done          <= done_nxt;
            err           <= err_nxt;
        end
    end

    // Next-state and next-output logic. The outputs are computed one cycle
    // ahead so that they are registered in the cycle they apply to.
    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        scnt_nxt      = scnt;
        shreg_nxt     = shreg;
        rb_shadow_nxt = rb_shadow;
        rb_data_nxt   = rb_data;
        en_nxt        = config_enable;
        head_nxt      = ccff_head;
        busy_nxt      = busy;
        done_nxt      = 1'b0;
        err_nxt       = 1'b0;

        case (state)
            S_IDLE: begin
                if (cfg_valid) begin
                    state_nxt = S_SHIFT;
                    cnt_nxt   = '0;
                    shreg_nxt = cfg_data[CHAIN_LEN-2:0];
                    head_nxt  = cfg_data[CHAIN_LEN-1];
                    en_nxt    = 1'b1;
                    busy_nxt  = 1'b1;
                end
            end
            S_SHIFT: begin
                // The chain shifts on this same edge, so ccff_tail currently
                // shows old bit CHAIN_LEN-1-cnt. Shifting it in from the LSB
                // leaves the first captured bit at the MSB after a full pass.
                rb_shadow_nxt = {rb_shadow[CHAIN_LEN-2:0], ccff_tail};
                if (cfg_abort) begin
                    state_nxt = S_DONE;
                    cnt_nxt   = '0;
                    en_nxt    = 1'b0;
                    head_nxt  = 1'b0;
                    busy_nxt  = 1'b0;
                    done_nxt  = 1'b1;
                    err_nxt   = 1'b1;
                end else if (cnt == CW'(CHAIN_LEN - 1)) begin
                    state_nxt = S_SETTLE;
                    cnt_nxt   = '0;
                    scnt_nxt  = '0;
                    en_nxt    = 1'b0;
                    head_nxt  = 1'b0;
                end else begin
                    cnt_nxt   = cnt + CW'(1);
                    head_nxt  = shreg[CHAIN_LEN-2];
                    shreg_nxt = {shreg[CHAIN_LEN-3:0], 1'b0};
                end
            end
            S_SETTLE: begin
                if (cfg_abort) begin
                    state_nxt = S_DONE;
                    busy_nxt  = 1'b0;
                    done_nxt  = 1'b1;
                    err_nxt   = 1'b1;
                end else if (scnt == SW'(SETTLE_CYCLES - 1)) begin
                    state_nxt   = S_DONE;
                    rb_data_nxt = rb_shadow;
                    busy_nxt    = 1'b0;
                    done_nxt    = 1'b1;
                end else begin
                    scnt_nxt = scnt + SW'(1);
                end
            end
            S_DONE: begin
                // The single non-busy cycle here is the gap between loads.
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

endmodule

// File: doc/frac_lut6_ccff_loader.md
# frac_lut6_ccff_loader

Sequencer that programs one fracturable-LUT6 configuration chain (64 LUT SRAM bits plus 2 mode bits, 66 CCFF stages) from a parallel configuration word. It accepts a word over a valid/ready handshake and shifts it serially into the chain through `ccff_head`, gating the chain with `config_enable`. While shifting, it captures the old chain contents from `ccff_tail` for readback. It sits between the fabric configuration bus and the per-tile `config_enable`/`ccff_head`/`ccff_tail` pins of the CLB logical tile.

## Interface

Parameters:
- `CHAIN_LEN`, default 66: number of CCFF stages. Word bit i maps to chain `mem_out[i]`: bits 0..63 are `sram[0:63]`, bits 64..65 are `mode[0:1]`.
- `SETTLE_CYCLES`, default 2: idle cycles with `config_enable` low after the last shift and before `done`. Legal range ≥1.

Ports:
- `prog_clock`, input, 1: configuration clock. All state changes on its rising edge.
- `prog_reset_n`, input, 1: asynchronous, active-low reset.
- `cfg_valid`, input, 1: a configuration word is offered.
- `cfg_ready`, output, 1: the loader accepts a word this cycle.
- `cfg_data`, input, CHAIN_LEN: the configuration word.
- `cfg_abort`, input, 1: abort the load in progress.
- `config_enable`, output, 1: shift enable to the CCFF chain.
- `ccff_head`, output, 1: serial data into the chain.
- `ccff_tail`, input, 1: serial data out of the chain.
- `busy`, output, 1: a load is in progress (SHIFT or SETTLE).
- `done`, output, 1: one-cycle pulse when a load completes or aborts.
- `err`, output, 1: valid with `done`; 1 means the load was aborted.
- `rb_data`, output, CHAIN_LEN: chain contents before the last completed load.

## Operation

- **Registered outputs.** All outputs are registered except `cfg_ready`, which is combinational and equals (state==IDLE).
- **Reset values.** IDLE, `config_enable`=0, `ccff_head`=0, `busy`=0, `done`=0, `err`=0, `rb_data`=0, shift counter=0.
- **IDLE.**
  - `cfg_valid`&&`cfg_ready` latches `cfg_data` into the shift register.
  - Next state is SHIFT with counter k=0.
  - `cfg_abort` in IDLE is ignored.
- **SHIFT.** For cycle k = 0..CHAIN_LEN-1:
  - `config_enable`=1 and `ccff_head`=`cfg_data[CHAIN_LEN-1-k]`, so the MSB goes first and bit 0 goes last.
  - At the end of cycle k, capture `ccff_tail` into `rb_shadow[CHAIN_LEN-1-k]`. This is the old chain bit `mem_out[CHAIN_LEN-1-k]`.
  - After cycle CHAIN_LEN-1, go to SETTLE.
- **SETTLE.**
  - `config_enable`=0 and `ccff_head`=0 for SETTLE_CYCLES cycles.
  - On the last of these cycles, copy `rb_shadow` to `rb_data`.
  - Next state is DONE.
- **DONE.**
  - `done`=1 and `err`=0 for exactly one cycle, then IDLE.
  - The `busy`=0 cycle in DONE gives a minimum one-cycle gap between loads.
- **Abort.**
  - `cfg_abort`=1 sampled in SHIFT or SETTLE: the next cycle is DONE with `err`=1, then IDLE.
  - `config_enable` drops on that same next edge.
  - `rb_data` is not updated.
  - The chain holds a partially shifted word; software must reload it.
- **Counter.** Width $clog2(CHAIN_LEN+1). It never wraps: SHIFT exits exactly at k=CHAIN_LEN-1.
- **Busy.** `busy`=1 in SHIFT and SETTLE only.
- **Reset mid-operation.** Everything returns to reset values asynchronously. `config_enable` drops immediately, so no further chain shifts occur. The chain keeps its partial contents.

## Timing

- Handshake edge = the rising edge where `cfg_valid`&&`cfg_ready`.
- First `config_enable`=1 cycle starts at handshake edge +1 and lasts CHAIN_LEN cycles.
- The chain's final value is present after edge handshake+CHAIN_LEN.
- `done` is high in cycle handshake+CHAIN_LEN+SETTLE_CYCLES+1. The default total is 69 cycles from handshake to `done`.
- `rb_data` is valid in the same cycle `done` rises.
- Next acceptance is possible at the earliest on the edge ending the `done` cycle + 1, i.e. when back in IDLE.
- Throughput: one word per CHAIN_LEN+SETTLE_CYCLES+2 cycles.
- Abort latency: `cfg_abort` sampled at edge E, `done`/`err` high in cycle E+1, IDLE at E+2.

## Test plan

- **Reset to IDLE.** Assert `prog_reset_n`=0 mid-cycle, then release.
  - Required: `cfg_ready`=1, `config_enable`=0, `ccff_head`=0, `rb_data`=0, `done`=0.
- **Single load.** Use a 66-stage chain model. Chain preloaded with 66'h2_AAAA_AAAA_AAAA_AAAA; load `cfg_data`=66'h1_0123_4567_89AB_CDEF.
  - Required: exactly 66 `config_enable` cycles.
  - Required: chain `mem_out`=66'h1_0123_4567_89AB_CDEF.
  - Required: `rb_data`=66'h2_AAAA_AAAA_AAAA_AAAA and `done`=1 at handshake+69.
- **Back-to-back loads.** Hold `cfg_valid` high with words A then B.
  - Required: `cfg_ready` low from handshake+1 through the `done` cycle.
  - Required: B accepted on the first IDLE cycle.
  - Required: after B, `rb_data`=A and the chain holds B.
- **Abort mid-shift.** Assert `cfg_abort` at SHIFT k=20.
  - Required: `config_enable` low next cycle, with exactly 21 chain shifts total.
  - Required: `done`=1 with `err`=1 for one cycle, and `rb_data` unchanged.
  - Required: a subsequent full load restores a correct chain.
- **Reset mid-load.** Assert `prog_reset_n`=0 at SHIFT k=40.
  - Required: `config_enable` falls immediately (asynchronously), with no further shifts and no `done` pulse.
  - Required: after release, `cfg_ready`=1.
- **Ignored inputs in IDLE.** Apply `cfg_abort` in IDLE and `cfg_valid`=0 during SHIFT.
  - Required: no state change and no `done`.
  - Required: `cfg_data` changes after the handshake do not alter the shifted bits.
